bp_mem_noc_responder: RTL and testbench

- Memory-side endpoint of the processor's DRAM command/response ready-and links.
- Accepts wormhole request packets (header flit plus optional data flits) from a processor's dram_cmd link and services them against an internal word-addressed memory array.
- Returns response packets on the dram_resp link.
- Used as the DRAM stand-in for top-level trace demo benches and as the reference responder for mem-NoC protocol checks.

---
 rtl/bp_mem_noc_pkg.sv | 34 +++
 rtl/bp_mem_noc_responder_mem.sv | 26 ++
 rtl/bp_mem_noc_responder.sv | 189 ++++++++++++++++++
 tb/tb_bp_mem_noc_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_mem_noc_pkg.sv
// Shared types for the mem-NoC responder: opcodes, header flit layout, FSM states.
package bp_mem_noc_pkg;

    localparam int unsigned cord_width_gp   = 8;
    localparam int unsigned len_width_gp    = 4;
    localparam int unsigned opcode_width_gp = 2;
    localparam int unsigned addr_width_gp   = 32;
    localparam int unsigned hdr_width_gp    = 56;

    typedef enum logic [opcode_width_gp-1:0] {
        e_mem_read  = 2'd0,
        e_mem_write = 2'd1
    } mem_opcode_e;

    // Header flit, LSB first: dst[7:0] len[11:8] opcode[13:12] rsvd[15:14] src[23:16] addr[55:24]
    typedef struct packed {
        logic [addr_width_gp-1:0]   addr;
        logic [cord_width_gp-1:0]   src_cord;
        logic [1:0]                 rsvd;
        logic [opcode_width_gp-1:0] opcode;
        logic [len_width_gp-1:0]    len;
        logic [cord_width_gp-1:0]   dst_cord;
    } mem_hdr_s;

    typedef enum logic [2:0] {
        e_idle,
        e_wdata,
        e_drain,
        e_rhdr,
        e_rdata,
        e_whdr
    } resp_state_e;

endpackage

// File: rtl/bp_mem_noc_responder_mem.sv
// Word array with one synchronous write port and one asynchronous read port.
module bp_mem_noc_responder_mem #(
    parameter  int unsigned els_p         = 4096,
    parameter  int unsigned width_p       = 64,
    localparam int unsigned addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    // Write port; contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_mem_noc_responder.sv
// Memory-side endpoint of the DRAM cmd/resp ready-and links, one request in flight.
module bp_mem_noc_responder
    import bp_mem_noc_pkg::*;
#(
    parameter  int unsigned flit_width_p  = 64,
    parameter  int unsigned block_beats_p = 8,
    parameter  int unsigned mem_els_p     = 4096,
    localparam int unsigned link_width_lp = flit_width_p + 2
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [link_width_lp-1:0] cmd_link_i,
    output logic [link_width_lp-1:0] cmd_link_o,
    output logic [link_width_lp-1:0] resp_link_o,
    input  logic [link_width_lp-1:0] resp_link_i,
    output logic                     err_o
);

    localparam int unsigned idx_width_lp  = $clog2(mem_els_p);
    localparam int unsigned beat_width_lp = $clog2(block_beats_p);
    localparam logic [len_width_gp-1:0] block_len_lp = len_width_gp'(block_beats_p);
    localparam logic [len_width_gp-1:0] last_beat_lp = len_width_gp'(block_beats_p - 1);

    resp_state_e               state_r;
    logic [len_width_gp-1:0]   cnt_r;
    logic [len_width_gp-1:0]   len_r;
    logic [cord_width_gp-1:0]  src_r;
    logic [addr_width_gp-1:0]  addr_r;
    logic [idx_width_lp-1:0]   index_r;
    logic [opcode_width_gp-1:0] opcode_r;
    logic                      cmd_ready_r;
    logic                      resp_v_r;
    logic                      err_r;

    logic                      cmd_v;
    logic [flit_width_p-1:0]   cmd_data;
    mem_hdr_s                  cmd_hdr;
    logic                      resp_ready;
    logic                      cmd_fire;
    logic                      resp_fire;
    logic                      hdr_is_read;
    logic                      hdr_is_write;
    logic [idx_width_lp-1:0]   hdr_index;
    logic [idx_width_lp-1:0]   mem_addr;
    logic                      mem_w_v;
    logic [flit_width_p-1:0]   mem_rdata;
    mem_hdr_s                  resp_hdr;
    logic [flit_width_p-1:0]   resp_data;
    logic                      unused_bits;

    assign cmd_v      = cmd_link_i[flit_width_p+1];
    assign cmd_data   = cmd_link_i[flit_width_p-1:0];
    assign cmd_hdr    = mem_hdr_s'(cmd_data[hdr_width_gp-1:0]);
    assign resp_ready = resp_link_i[flit_width_p];
    assign cmd_fire   = cmd_v & cmd_ready_r;
    assign resp_fire  = resp_v_r & resp_ready;

    assign unused_bits = ^{cmd_link_i[flit_width_p], cmd_data[flit_width_p-1:hdr_width_gp],
                           cmd_hdr.dst_cord, cmd_hdr.rsvd,
                           resp_link_i[flit_width_p+1], resp_link_i[flit_width_p-1:0]};

    assign hdr_is_read  = (cmd_hdr.opcode == e_mem_read)  && (cmd_hdr.len == '0);
    assign hdr_is_write = (cmd_hdr.opcode == e_mem_write) && (cmd_hdr.len == block_len_lp);

    // Block-aligned word index; address bits above the array wrap
    assign hdr_index = {cmd_hdr.addr[3+beat_width_lp +: idx_width_lp-beat_width_lp],
                        beat_width_lp'(0)};

    assign mem_addr = index_r + idx_width_lp'(cnt_r);
    assign mem_w_v  = cmd_fire && (state_r == e_wdata);

    bp_mem_noc_responder_mem #(
        .els_p   (mem_els_p),
        .width_p (flit_width_p)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (mem_addr),
        .w_data_i (cmd_data),
        .r_addr_i (mem_addr),
        .r_data_o (mem_rdata)
    );

    // Response header assembled from the latched request fields
    always_comb begin
        resp_hdr          = '0;
        resp_hdr.dst_cord = src_r;
        resp_hdr.len      = (state_r == e_rhdr) ? block_len_lp : '0;
        resp_hdr.opcode   = opcode_r;
        resp_hdr.src_cord = '0;
        resp_hdr.addr     = addr_r;
    end

    assign resp_data = (state_r == e_rdata) ? mem_rdata : flit_width_p'(resp_hdr);

    assign cmd_link_o  = {1'b0, cmd_ready_r, {flit_width_p{1'b0}}};
    assign resp_link_o = {resp_v_r, 1'b0, resp_data};
    assign err_o       = err_r;

    // Request/response FSM with registered link handshakes and error pulse
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= e_idle;
            cnt_r       <= '0;
            len_r       <= '0;
            src_r       <= '0;
            addr_r      <= '0;
            index_r     <= '0;
            opcode_r    <= '0;
            cmd_ready_r <= 1'b0;
            resp_v_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                e_idle: begin
                    cmd_ready_r <= 1'b1;
                    if (cmd_fire) begin
                        src_r    <= cmd_hdr.src_cord;
                        addr_r   <= cmd_hdr.addr;
                        index_r  <= hdr_index;
                        opcode_r <= cmd_hdr.opcode;
                        len_r    <= cmd_hdr.len;
                        cnt_r    <= '0;
                        if (hdr_is_read) begin
                            state_r     <= e_rhdr;
                            cmd_ready_r <= 1'b0;
                            resp_v_r    <= 1'b1;
                        end else if (hdr_is_write) begin
                            state_r <= e_wdata;
                        end else begin
                            err_r <= 1'b1;
                            if (cmd_hdr.len != '0) begin
                                state_r <= e_drain;
                            end
                        end
                    end
                end
                e_wdata: begin
                    if (cmd_fire) begin
                        cnt_r <= cnt_r + len_width_gp'(1);
                        if (cnt_r == last_beat_lp) begin
                            state_r     <= e_whdr;
                            cnt_r       <= '0;
                            cmd_ready_r <= 1'b0;
                            resp_v_r    <= 1'b1;
                        end
                    end
                end
                e_drain: begin
                    if (cmd_fire) begin
                        cnt_r <= cnt_r + len_width_gp'(1);
                        if (cnt_r == len_r - len_width_gp'(1)) begin
                            state_r <= e_idle;
                            cnt_r   <= '0;
                        end
                    end
                end
                e_rhdr: begin
                    if (resp_fire) begin
                        state_r <= e_rdata;
                    end
                end
                e_rdata: begin
                    if (resp_fire) begin
                        cnt_r <= cnt_r + len_width_gp'(1);
                        if (cnt_r == last_beat_lp) begin
                            state_r     <= e_idle;
                            cnt_r       <= '0;
                            resp_v_r    <= 1'b0;
                            cmd_ready_r <= 1'b1;
                        end
                    end
                end
                e_whdr: begin
                    if (resp_fire) begin
                        state_r     <= e_idle;
                        resp_v_r    <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= e_idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bp_mem_noc_responder.sv
// Directed bench for bp_mem_noc_responder: write/read, alignment, stalls, errors, reset, back-to-back.
module tb_bp_mem_noc_responder;

    logic        clk;
    logic        rst_n;
    logic        cmd_v;
    logic [63:0] cmd_data;
    logic        resp_ready;
    logic [65:0] cmd_link_o;
    logic [65:0] resp_link_o;
    logic        err;

    logic        cmd_ready;
    logic        resp_v;
    logic [63:0] resp_data;

    int n_checks;
    int n_fail;

    logic [63:0] mem_m [0:4095];

    assign cmd_ready = cmd_link_o[64];
    assign resp_v    = resp_link_o[65];
    assign resp_data = resp_link_o[63:0];

    bp_mem_noc_responder dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .cmd_link_i  ({cmd_v, 1'b0, cmd_data}),
        .cmd_link_o  (cmd_link_o),
        .resp_link_o (resp_link_o),
        .resp_link_i ({1'b0, resp_ready, 64'h0}),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Request header: dst fixed at 1
    function automatic logic [63:0] req_hdr(input logic [1:0] op, input logic [3:0] len,
                                            input logic [7:0] src, input logic [31:0] addr);
        return {8'h00, addr, src, 2'b00, op, len, 8'h01};
    endfunction

    // Expected response header: dst = requester, src = 0
    function automatic logic [63:0] rsp_hdr(input logic [1:0] op, input logic [3:0] len,
                                            input logic [7:0] dst, input logic [31:0] addr);
        return {8'h00, addr, 8'h00, 2'b00, op, len, dst};
    endfunction

    // Drive one flit at a negedge; returns at the negedge after it transferred
    task automatic send(input logic [63:0] d);
        int n;
        n = 0;
        cmd_v    = 1'b1;
        cmd_data = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("send_timeout", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        cmd_v = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] src, input logic [31:0] addr, input int idx,
                            input logic [63:0] base, input int nbeats);
        send(req_hdr(2'd1, 4'd8, src, addr));
        check_eq("wr_hdr_err", 64'(err), 64'd0);
        for (int b = 0; b < nbeats; b++) begin
            send(base + 64'(b));
            mem_m[idx + b] = base + 64'(b);
        end
        if (nbeats == 8) begin
            check_eq("wr_ack_v", 64'(resp_v), 64'd1);
            check_eq("wr_ack_hdr", resp_data, rsp_hdr(2'd1, 4'd0, src, addr));
            @(negedge clk);
            check_eq("wr_ack_done_v", 64'(resp_v), 64'd0);
            check_eq("wr_ack_done_rdy", 64'(cmd_ready), 64'd1);
        end
    endtask

    // READ request; bit c of rdy_mask is resp ready for data cycle c
    task automatic do_read(input logic [7:0] src, input logic [31:0] addr, input int idx,
                           input int nchk, input logic [31:0] rdy_mask);
        int k;
        int cyc;
        logic rdy;
        resp_ready = 1'b1;
        send(req_hdr(2'd0, 4'd0, src, addr));
        check_eq("rd_hdr_v", 64'(resp_v), 64'd1);
        check_eq("rd_hdr", resp_data, rsp_hdr(2'd0, 4'd8, src, addr));
        check_eq("rd_hdr_cmd_rdy", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 32) begin
            check_eq("rd_beat_v", 64'(resp_v), 64'd1);
            if (k < nchk) check_eq($sformatf("rd_beat%0d", k), resp_data, mem_m[idx + k]);
            rdy        = rdy_mask[cyc];
            resp_ready = rdy;
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        resp_ready = 1'b1;
        if (k < 8) check_eq("rd_beats_timeout", 64'(k), 64'd8);
        check_eq("rd_done_v", 64'(resp_v), 64'd0);
        check_eq("rd_done_rdy", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        cmd_v      = 1'b0;
        cmd_data   = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_rdy", 64'(cmd_ready), 64'd0);
        check_eq("rst_resp_v", 64'(resp_v), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("cmd_link_ties", {cmd_link_o[65], cmd_link_o[63:0]}, 64'd0);
        check_eq("resp_link_tie", 64'(resp_link_o[64]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_cmd_rdy", 64'(cmd_ready), 64'd1);

        // Write then read block at word 8
        do_write(8'd3, 32'h40, 8, 64'h1000, 8);
        do_read(8'd3, 32'h40, 8, 8, 32'hFFFF_FFFF);

        // Mid-block address reads the aligned block
        do_read(8'd4, 32'h58, 8, 8, 32'hFFFF_FFFF);

        // Resp ready 1,0,0,1 during RDATA
        do_read(8'd3, 32'h40, 8, 8, 32'hFFFF_FFF9);

        // Malformed opcode 2, len 3: error pulse, 3 flits drained, no response
        send(req_hdr(2'd2, 4'd3, 8'd9, 32'h40));
        check_eq("bad_err_pulse", 64'(err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            send(64'hDEAD_0000 + 64'(i));
            check_eq("drain_err_low", 64'(err), 64'd0);
            check_eq("drain_resp_v", 64'(resp_v), 64'd0);
        end
        check_eq("drain_done_rdy", 64'(cmd_ready), 64'd1);
        do_read(8'd9, 32'h40, 8, 8, 32'hFFFF_FFFF);

        // Malformed with len 0 stays in IDLE
        send(req_hdr(2'd3, 4'd0, 8'd2, 32'h0));
        check_eq("bad0_err_pulse", 64'(err), 64'd1);
        check_eq("bad0_cmd_rdy", 64'(cmd_ready), 64'd1);
        check_eq("bad0_resp_v", 64'(resp_v), 64'd0);
        @(negedge clk);
        check_eq("bad0_err_low", 64'(err), 64'd0);

        // Reset after 4 of 8 write beats
        do_write(8'd5, 32'h80, 16, 64'h2000, 4);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cmd_rdy", 64'(cmd_ready), 64'd0);
        check_eq("midrst_resp_v", 64'(resp_v), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_post_rdy", 64'(cmd_ready), 64'd1);
        check_eq("midrst_post_v", 64'(resp_v), 64'd0);
        do_read(8'd5, 32'h80, 16, 4, 32'hFFFF_FFFF);

        // Back-to-back READ headers: 9 not-ready cycles between accepts
        resp_ready = 1'b1;
        cmd_v      = 1'b1;
        cmd_data   = req_hdr(2'd0, 4'd0, 8'd6, 32'h40);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n = 0;
            while (!cmd_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            check_eq($sformatf("b2b_gap%0d", r), 64'(n), 64'd9);
        end
        cmd_v = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle_v", 64'(resp_v), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
